// File: rtl/tq_tr_sched.sv
// Job scheduler sharing the 2D DCT/IDCT engine between the forward (residual)
// and inverse (dequantised coefficient) requesters, with a drain gap on direction change.
`timescale 1ns/1ps
module tq_tr_sched #(
  parameter int unsigned GAP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_fwd_req,
  input  logic [1:0] i_fwd_size,
  input  logic       i_fwd_vld,
  input  logic       i_inv_req,
  input  logic [1:0] i_inv_size,
  input  logic       i_inv_vld,
  output logic       o_fwd_gnt,
  output logic       o_inv_gnt,
  output logic       o_inverse,
  output logic       o_valid,
  output logic [1:0] o_size,
  output logic       o_last,
  output logic       o_busy
);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_t     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic       dir_q, dir_d;
  logic [1:0] size_q, size_d;
  logic [4:0] cnt_q, cnt_d;
  logic [3:0] gap_q, gap_d;
  logic       last_dir_q, last_dir_d;
  logic       served_q, served_d;

  logic       any_req;
  logic       win_inv;
  logic [1:0] win_size;
  logic       cur_vld;
  logic       other_req;
  logic       same_req;
  logic [1:0] same_size;
  logic [4:0] last_idx;

  // Tie goes to the direction not served last; last_dir resets to inverse.
  assign any_req   = i_fwd_req | i_inv_req;
  assign win_inv   = i_inv_req & (~i_fwd_req | ~last_dir_q);
  assign win_size  = win_inv ? i_inv_size : i_fwd_size;
  assign cur_vld   = dir_q ? i_inv_vld : i_fwd_vld;
  assign other_req = dir_q ? i_fwd_req : i_inv_req;
  assign same_req  = dir_q ? i_inv_req : i_fwd_req;
  assign same_size = dir_q ? i_inv_size : i_fwd_size;

  always_comb begin
    case (size_q)
      2'd0:    last_idx = 5'd3;
      2'd1:    last_idx = 5'd7;
      2'd2:    last_idx = 5'd15;
      default: last_idx = 5'd31;
    endcase
  end

  assign o_fwd_gnt = gnt_q & ~dir_q;
  assign o_inv_gnt = gnt_q & dir_q;
  assign o_inverse = dir_q;
  assign o_valid   = gnt_q & cur_vld;
  assign o_last    = o_valid & (cnt_q == last_idx);
  assign o_size    = size_q;
  assign o_busy    = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    dir_d      = dir_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    last_dir_d = last_dir_q;
    served_d   = served_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          // No drain is needed before the first job after reset.
          if (served_q && (win_inv != last_dir_q)) begin
            state_d = GAP;
            gap_d   = '0;
          end else begin
            state_d = RUN;
            gnt_d   = 1'b1;
            dir_d   = win_inv;
            size_d  = win_size;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        if (!gnt_q) begin
          // Grant-low cycle between back-to-back same-direction jobs.
          gnt_d = 1'b1;
        end else if (o_valid) begin
          cnt_d = cnt_q + 5'd1;
          if (o_last) begin
            last_dir_d = dir_q;
            served_d   = 1'b1;
            gnt_d      = 1'b0;
            cnt_d      = '0;
            if (other_req) begin
              state_d = GAP;
              gap_d   = '0;
            end else if (same_req) begin
              state_d = RUN;
              size_d  = same_size;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          if (any_req) begin
            state_d = RUN;
            gnt_d   = 1'b1;
            dir_d   = win_inv;
            size_d  = win_size;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      dir_q      <= 1'b0;
      size_q     <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
      last_dir_q <= 1'b1;
      served_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      dir_q      <= dir_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      last_dir_q <= last_dir_d;
      served_q   <= served_d;
    end
  end

endmodule

// File: tb/tb_tq_tr_sched.sv
// Directed self-checking bench for tq_tr_sched with GAP_CYC=4.
`timescale 1ns/1ps
module tb_tq_tr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       fwd_req, fwd_vld, inv_req, inv_vld;
  logic [1:0] fwd_size, inv_size;
  logic       o_fwd_gnt, o_inv_gnt, o_inverse, o_valid, o_last, o_busy;
  logic [1:0] o_size;

  int checks = 0;
  int failures = 0;

  tq_tr_sched #(.GAP_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .i_fwd_req(fwd_req), .i_fwd_size(fwd_size), .i_fwd_vld(fwd_vld),
    .i_inv_req(inv_req), .i_inv_size(inv_size), .i_inv_vld(inv_vld),
    .o_fwd_gnt(o_fwd_gnt), .o_inv_gnt(o_inv_gnt), .o_inverse(o_inverse),
    .o_valid(o_valid), .o_size(o_size), .o_last(o_last), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {o_fwd_gnt, o_inv_gnt, o_inverse, o_valid, o_size, o_last, o_busy};
  endfunction

  // One job with the requester's vld held high or toggling 1,0,... from the grant.
  task automatic do_job(input string tag, input logic inv, input logic [1:0] sz,
                        input int exp_lat, input logic tog);
    int lat, c, beats, last_at, badv, badi, n;
    logic g, v;
    n = 4 << sz;
    cyc();
    if (inv) begin inv_req = 1'b1; inv_size = sz; end
    else     begin fwd_req = 1'b1; fwd_size = sz; end
    smp();
    lat = 0;
    g = inv ? o_inv_gnt : o_fwd_gnt;
    while (!g && lat < 40) begin
      cyc(); smp(); lat++;
      g = inv ? o_inv_gnt : o_fwd_gnt;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    fwd_req = 1'b0; inv_req = 1'b0;
    beats = 0; last_at = 0; badv = 0; badi = 0; c = 0;
    while (g && c < 80) begin
      v = tog ? ~c[0] : 1'b1;
      if (inv) inv_vld = v; else fwd_vld = v;
      #1;
      if (o_valid) beats++;
      if (o_valid && !v) badv++;
      if (o_last) last_at = beats;
      if (o_inverse !== inv) badi++;
      cyc(); smp(); c++;
      g = inv ? o_inv_gnt : o_fwd_gnt;
    end
    fwd_vld = 1'b0; inv_vld = 1'b0;
    chk({tag, "_beats"}, beats, n);
    chk({tag, "_last_at"}, last_at, n);
    chk({tag, "_vld_gate"}, badv, 0);
    chk({tag, "_dir"}, badi, 0);
    chk({tag, "_busy_end"}, o_busy, 1'b0);
    chk({tag, "_dir_hold"}, o_inverse, inv);
  endtask

  initial begin
    int beats, bad, gap, lat, last_c;
    rst = 1'b1;
    fwd_req = 0; fwd_vld = 0; fwd_size = 0;
    inv_req = 0; inv_vld = 0; inv_size = 0;
    cyc(); cyc(); smp();
    chk("reset", outs(), 8'h00);
    rst = 1'b0;

    // forward 4x4 straight from reset: no gap
    do_job("t1", 1'b0, 2'd0, 1, 1'b0);
    // inverse 32x32 after forward: drain gap, vld toggling
    do_job("t2", 1'b1, 2'd3, 5, 1'b1);

    // both requests from reset: forward first, gap, then inverse
    rst = 1'b1;
    cyc(); cyc(); smp();
    chk("t3_reset", outs(), 8'h00);
    rst = 1'b0;
    cyc();
    fwd_req = 1; inv_req = 1; fwd_size = 1; inv_size = 1; fwd_vld = 1; inv_vld = 0;
    smp();
    chk("t3_idle", {o_fwd_gnt, o_inv_gnt}, 2'b00);
    cyc(); fwd_req = 0; smp();
    chk("t3_fwd_first", {o_fwd_gnt, o_inv_gnt}, 2'b10);
    beats = 0; bad = 0; last_c = -1;
    for (int c = 0; c < 8; c++) begin
      inv_vld = c[0];
      #1;
      if (o_valid) beats++; else bad++;
      if (o_inverse) bad++;
      if (o_last) last_c = c;
      cyc(); smp();
    end
    chk("t3_fwd_beats", beats, 8);
    chk("t3_fwd_last", last_c, 7);
    chk("t3_fwd_bad", bad, 0);
    inv_vld = 1; gap = 0; bad = 0;
    while (!o_inv_gnt && gap < 20) begin
      if (o_inverse || o_valid || o_fwd_gnt) bad++;
      gap++;
      cyc(); smp();
    end
    chk("t3_gap_len", gap, 4);
    chk("t3_gap_quiet", bad, 0);
    inv_req = 0; beats = 0; bad = 0;
    for (int c = 0; c < 8; c++) begin
      if (o_valid) beats++;
      if (!o_inverse) bad++;
      cyc(); smp();
    end
    inv_vld = 0;
    chk("t3_inv_beats", beats, 8);
    chk("t3_inv_dir", bad, 0);
    chk("t3_busy_end", o_busy, 1'b0);

    // back-to-back forward 8x8 (after inverse, so first grant sees the gap)
    cyc();
    fwd_req = 1; fwd_size = 1; fwd_vld = 1;
    smp();
    lat = 0;
    while (!o_fwd_gnt && lat < 20) begin cyc(); smp(); lat++; end
    chk("t4_lat", lat, 5);
    beats = 0; last_c = -1;
    for (int c = 0; c < 8; c++) begin
      if (o_valid) beats++;
      if (o_last) last_c = c;
      cyc(); smp();
    end
    chk("t4_j1_beats", beats, 8);
    chk("t4_j1_last", last_c, 7);
    chk("t4_gnt_low", {o_fwd_gnt, o_inv_gnt, o_busy}, 3'b001);
    fwd_req = 0; fwd_size = 3;
    cyc(); smp();
    chk("t4_regrant", o_fwd_gnt, 1'b1);
    chk("t4_size_latched", o_size, 2'd1);
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      if (o_valid) beats++;
      cyc(); smp();
    end
    fwd_vld = 0;
    chk("t4_j2_beats", beats, 8);
    chk("t4_busy_end", o_busy, 1'b0);

    // reset at beat 10 of a forward 16x16 job
    cyc();
    fwd_req = 1; fwd_size = 2; fwd_vld = 1;
    smp();
    cyc(); fwd_req = 0; smp();
    chk("t5_gnt", o_fwd_gnt, 1'b1);
    beats = 1;
    for (int c = 0; c < 9; c++) begin
      cyc(); smp();
      if (o_valid) beats++;
    end
    chk("t5_beat10", {beats[7:0], o_valid, o_last}, {8'd10, 2'b10});
    rst = 1'b1;
    cyc(); smp();
    chk("t5_reset_outs", outs(), 8'h00);
    rst = 1'b0; fwd_vld = 0;
    do_job("t5b", 1'b0, 2'd0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
